size_count_sched: RTL and testbench

- Shares one size_count instance between NREQ requesters.
- Arbitrates pending transfer requests, each a size in beats.
- Sequences the counter handshake for the winner: size_valid load, then data_start, then wait for last.
- Reports completion per requester; sits between the packet sources and the shared size counter.

---
 rtl/size_count_sched.sv | 119 +++++++++++
 tb/tb_size_count_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/size_count_sched.sv
// Arbitrates NREQ transfer requests onto one shared size counter and sequences its load/start/last handshake.
// Latency: one cycle from IDLE sampling a request to LOAD; the requester waits (holding req_valid) until req_ack.
// Optional: define SIZE_COUNT_SCHED_RR_EN for round-robin arbitration (default is fixed priority, lowest index).
module size_count_sched #(
  parameter int NREQ   = 4,
  parameter int SIZE_W = 32,
  parameter int ID_W   = 2
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*SIZE_W-1:0] req_size,
  output logic [NREQ-1:0]        req_ack,
  input  logic                   data_go,
  output logic                   cnt_size_valid,
  output logic [SIZE_W-1:0]      cnt_size,
  output logic                   cnt_data_start,
  input  logic                   cnt_last,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic                   err_zero
);

  typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   win_oh;
  logic              win_found;
  logic [ID_W-1:0]   win;
  logic [SIZE_W-1:0] win_size;
  int                best_d;
  int                d;

  // A requester whose ack is on the wire this cycle has not had a chance to drop or refresh its request yet.
  always_comb begin
    elig      = req_valid & ~req_ack;
    win_found = 1'b0;
    win       = '0;
    win_oh    = '0;
    win_size  = '0;
    best_d    = NREQ;
    d         = 0;
    for (int j = 0; j < NREQ; j++) begin
      d = (j + NREQ - int'(rr_ptr)) % NREQ;
      if (elig[j] && d < best_d) begin
        best_d    = d;
        win_found = 1'b1;
        win       = ID_W'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_size  = req_size[j*SIZE_W +: SIZE_W];
      end
    end
  end

  assign cnt_data_start = (state == START) && data_go;

`ifndef SIZE_COUNT_SCHED_RR_EN
  assign rr_ptr = '0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state          <= IDLE;
      req_ack        <= '0;
      cnt_size_valid <= 1'b0;
      cnt_size       <= '0;
      busy           <= 1'b0;
      grant_id       <= '0;
      done           <= 1'b0;
      done_id        <= '0;
      err_zero       <= 1'b0;
`ifdef SIZE_COUNT_SCHED_RR_EN
      rr_ptr         <= '0;
`endif
    end else begin
      req_ack        <= '0;
      cnt_size_valid <= 1'b0;
      done           <= 1'b0;
      err_zero       <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_id <= win;
            cnt_size <= win_size;
            req_ack  <= win_oh;
`ifdef SIZE_COUNT_SCHED_RR_EN
            rr_ptr   <= ID_W'((int'(win) + 1) % NREQ);
`endif
            // A zero size would make the counter wrap rather than finish, so it never reaches the counter.
            if (win_size == '0) begin
              err_zero <= 1'b1;
            end else begin
              state          <= LOAD;
              cnt_size_valid <= 1'b1;
              busy           <= 1'b1;
            end
          end
        end
        LOAD:  state <= START;
        START: if (data_go) state <= RUN;
        RUN: begin
          if (cnt_last) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            done_id <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_size_count_sched.sv
// Bench for size_count_sched: requester queues drive the DUT, a behavioural size counter answers the
// handshake, and expected grants/completions are queued up front and checked as the DUT produces them.
module tb_size_count_sched;
  localparam int NREQ = 4;
  localparam int SIZE_W = 32;
  localparam int ID_W = 2;

  logic                   clock = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*SIZE_W-1:0] req_size = '0;
  logic [NREQ-1:0]        req_ack;
  logic                   data_go = 1'b0;
  logic                   cnt_size_valid;
  logic [SIZE_W-1:0]      cnt_size;
  logic                   cnt_data_start;
  logic                   cnt_last;
  logic                   busy;
  logic [ID_W-1:0]        grant_id;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic                   err_zero;

  size_count_sched #(.NREQ(NREQ), .SIZE_W(SIZE_W), .ID_W(ID_W)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_size(req_size), .req_ack(req_ack),
    .data_go(data_go), .cnt_size_valid(cnt_size_valid), .cnt_size(cnt_size),
    .cnt_data_start(cnt_data_start), .cnt_last(cnt_last), .busy(busy), .grant_id(grant_id),
    .done(done), .done_id(done_id), .err_zero(err_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // Behavioural shared counter: last fires N cycles after data_start for a size-N load.
  logic [SIZE_W-1:0] m_size, m_rem;
  logic              m_run;
  always @(posedge clock) begin
    if (rst) begin
      m_run <= 1'b0; m_rem <= '0; m_size <= '0;
    end else begin
      if (cnt_size_valid) m_size <= cnt_size;
      if (cnt_data_start) begin
        m_run <= 1'b1; m_rem <= m_size;
      end else if (m_run) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_run <= 1'b0;
      end
    end
  end
  assign cnt_last = m_run && (m_rem == 1);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { int id; int size; } exp_t;
  exp_t              exp_q[$];
  int                done_q[$];
  logic [SIZE_W-1:0] rq [NREQ][$];

  task automatic req(input int id, input int size);
    rq[id].push_back(SIZE_W'(size));
  endtask

  task automatic expect_grant(input int id, input int size, input bit with_done);
    exp_q.push_back('{id, size});
    if (with_done) done_q.push_back(id);
  endtask

  // Requesters: hold the head request until acked, then present the next one immediately.
  initial begin
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid[i] = (rq[i].size() > 0);
        req_size[i*SIZE_W +: SIZE_W] = (rq[i].size() > 0) ? rq[i][0] : '0;
      end
    end
  end

  int   n_sv = 0, n_ds = 0, n_done = 0, n_err = 0, n_ack = 0;
  int   last_cyc = 0;
  bit   last_vld = 1'b0;
  bit   gap_en = 1'b0;
  exp_t e;
  int   did;

  initial begin
    forever begin
      @(negedge clock);
      if (!rst) begin
        if (req_ack != '0) n_ack++;
        if (cnt_data_start) n_ds++;
        if (cnt_size_valid) begin
          n_sv++;
          if (gap_en && last_vld) begin
            check("b2b_gap", cyc - last_cyc, 2);
            gap_en = 1'b0;
          end
          check("sv_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sv_grant_id", grant_id, e.id);
            check("sv_cnt_size", cnt_size, e.size);
            check("sv_req_ack", req_ack, longint'(1) << e.id);
            check("sv_busy", busy, 1);
          end
        end
        if (err_zero) begin
          n_err++;
          check("zero_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("zero_grant_id", grant_id, e.id);
            check("zero_cnt_size", cnt_size, e.size);
            check("zero_req_ack", req_ack, longint'(1) << e.id);
            check("zero_busy", busy, 0);
          end
        end
        if (done) begin
          n_done++;
          check("done_expected", done_q.size() > 0, 1);
          if (done_q.size() > 0) begin
            did = done_q.pop_front();
            check("done_id", done_id, did);
            check("done_latency", cyc - last_cyc, 1);
            check("done_busy", busy, 0);
          end
        end
        if (cnt_last) begin
          last_cyc = cyc;
          last_vld = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_ack"}, req_ack, 0);
    check({tag, "_cnt_size_valid"}, cnt_size_valid, 0);
    check({tag, "_cnt_size"}, cnt_size, 0);
    check({tag, "_cnt_data_start"}, cnt_data_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_done_id"}, done_id, 0);
    check({tag, "_err_zero"}, err_zero, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clock); #1;
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_outs(tag);
    @(posedge clock); #1;
    rst = 1'b0;
    last_vld = 1'b0;
    gap_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() + done_q.size() != 0 || busy || req_valid != '0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    check({tag, "_drain"}, exp_q.size() + done_q.size(), 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  int b_sv, b_ds, b_ack, b_done, b_err;
  task automatic snap();
    b_sv = n_sv; b_ds = n_ds; b_ack = n_ack; b_done = n_done; b_err = n_err;
  endtask

  initial begin
    int n;
    do_reset("por");

    // Single request, size 5
    data_go = 1'b1;
    snap();
    req(0, 5); expect_grant(0, 5, 1);
    wait_drain("t1", 200);
    check("t1_sv_pulses", n_sv - b_sv, 1);
    check("t1_ds_pulses", n_ds - b_ds, 1);
    check("t1_ack_pulses", n_ack - b_ack, 1);
    check("t1_done_pulses", n_done - b_done, 1);

    // All four at once, one request each
    do_reset("t2a_rst");
    req(0, 3); req(1, 1); req(2, 2); req(3, 4);
    for (int i = 0; i < 4; i++) expect_grant(i, (i == 0) ? 3 : (i == 1) ? 1 : (i == 2) ? 2 : 4, 1);
    wait_drain("t2a", 400);

    // Requester 0 re-requests while 1..3 wait
    do_reset("t2b_rst");
    for (int k = 0; k < 3; k++) req(0, 2);
    req(1, 1); req(2, 1); req(3, 1);
`ifdef SIZE_COUNT_SCHED_RR_EN
    expect_grant(0, 2, 1); expect_grant(1, 1, 1); expect_grant(2, 1, 1);
    expect_grant(3, 1, 1); expect_grant(0, 2, 1); expect_grant(0, 2, 1);
`else
    expect_grant(0, 2, 1); expect_grant(0, 2, 1); expect_grant(0, 2, 1);
    expect_grant(1, 1, 1); expect_grant(2, 1, 1); expect_grant(3, 1, 1);
`endif
    wait_drain("t2b", 600);

    // Zero-size request is rejected, next requester served
    do_reset("t4_rst");
    snap();
    req(2, 0); req(3, 2);
    expect_grant(2, 0, 0); expect_grant(3, 2, 1);
    wait_drain("t4", 200);
    check("t4_sv_pulses", n_sv - b_sv, 1);
    check("t4_err_pulses", n_err - b_err, 1);

    // data_go held low in START
    data_go = 1'b0;
    snap();
    req(1, 2); expect_grant(1, 2, 1);
    n = 0;
    while (!cnt_size_valid && n < 50) begin @(negedge clock); n++; end
    check("t5_sv_seen", cnt_size_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("t5_hold_ds", cnt_data_start, 0);
      check("t5_hold_busy", busy, 1);
    end
    @(posedge clock); #1;
    data_go = 1'b1;
    @(negedge clock);
    check("t5_ds_on", cnt_data_start, 1);
    @(negedge clock);
    check("t5_ds_off", cnt_data_start, 0);
    wait_drain("t5", 200);
    check("t5_ds_pulses", n_ds - b_ds, 1);

    // Reset in RUN with 7 beats outstanding
    snap();
    req(1, 7); expect_grant(1, 7, 0);
    n = 0;
    while (n_ds == b_ds && n < 50) begin @(negedge clock); n++; end
    check("t6_ds_seen", n_ds - b_ds, 1);
    @(posedge clock); #1;
    rst = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_outs("t6");
    @(posedge clock); #1;
    rst = 1'b0;
    last_vld = 1'b0;
    repeat (10) @(negedge clock);
    check("t6_no_done", n_done - b_done, 0);
    req(2, 3); expect_grant(2, 3, 1);
    wait_drain("t6b", 200);

    // Back-to-back size-1 transfers
    do_reset("t7_rst");
    req(0, 1); req(1, 1);
    expect_grant(0, 1, 1); expect_grant(1, 1, 1);
    gap_en = 1'b1;
    wait_drain("t7", 200);
    check("t7_gap_checked", gap_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
